watch_timer_dp: RTL and testbench

WATCH_TIMER_DP -- requirements
Module: watch_timer_dp

---
 rtl/watch_pkg.sv | 21 ++
 rtl/watch_field.sv | 55 +++++
 rtl/watch_timer_dp.sv | 122 ++++++++++++
 tb/tb_watch_timer_dp.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// watch_pkg: shared constants for the watch/timer datapath.
//   Field moduli (centiseconds, seconds, minutes, hours) and the
//   encodings of the two-bit edit select.
package watch_pkg;

    localparam int MSEC_MOD = 100;
    localparam int SEC_MOD  = 60;
    localparam int MIN_MOD  = 60;
    localparam int HOUR_MOD = 24;

    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [1:0] SEL_MSEC = 2'd0;
    localparam logic [1:0] SEL_SEC  = 2'd1;
    localparam logic [1:0] SEL_MIN  = 2'd2;
    localparam logic [1:0] SEL_HOUR = 2'd3;

endpackage

// File: rtl/watch_field.sv
// watch_field: one modulo-MOD up/down counter stage of the watch.
//   clk, rst      clock, async active-high reset (loads RST_VAL)
//   clr           synchronous clear to 0, overrides everything
//   ci, bi        carry / borrow in from the stage below (never both)
//   edit_inc/dec  direct +1 / -1 edit of this field (mutually exclusive)
//   val           current field value, 0..MOD-1
//   co, bo        carry / borrow out to the stage above (combinational)
module watch_field #(
    parameter int             MOD     = 60,
    parameter int             W       = 6,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ci,
    input  logic         bi,
    input  logic         edit_inc,
    input  logic         edit_dec,
    output logic [W-1:0] val,
    output logic         co,
    output logic         bo
);

    localparam logic [W-1:0] MAXV = W'(MOD - 1);

    logic edit;
    logic at_max;
    logic at_min;

    assign edit   = edit_inc | edit_dec;
    assign at_max = (val == MAXV);
    assign at_min = (val == '0);

    // An edited field swallows any incoming carry/borrow, so nothing
    // propagates past it in that cycle.
    assign co = ci & ~edit & at_max;
    assign bo = bi & ~edit & at_min;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            val <= RST_VAL;
        else if (clr)
            val <= '0;
        else if (edit_inc)
            val <= at_max ? '0 : val + 1'b1;
        else if (edit_dec)
            val <= at_min ? MAXV : val - 1'b1;
        else if (ci)
            val <= at_max ? '0 : val + 1'b1;
        else if (bi)
            val <= at_min ? MAXV : val - 1'b1;
    end

endmodule

// File: rtl/watch_timer_dp.sv
// watch_timer_dp: centisecond watch / countdown timer datapath.
//   clk, rst   clock, async active-high reset (time = RST_HOUR:00:00.00)
//   run        prescaler advances when high
//   dir        0 = count up (watch), 1 = count down (timer)
//   clr        synchronous clear of fields and prescaler
//   sel        edit target (SEL_MSEC..SEL_HOUR)
//   inc, dec   single-cycle edit pulses; both together = no edit
//   msec/sec/min/hour   current time fields
//   zero       all fields zero (combinational)
//   expired    1-cycle pulse after a down-count reaches zero
//   day_tick   1-cycle pulse after an up-count wraps 23:59:59.99
module watch_timer_dp
    import watch_pkg::*;
#(
    parameter int FCOUNT   = 1_000_000,
    parameter int RST_HOUR = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              dir,
    input  logic              clr,
    input  logic [1:0]        sel,
    input  logic              inc,
    input  logic              dec,
    output logic [MSEC_W-1:0] msec,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic              zero,
    output logic              expired,
    output logic              day_tick
);

    localparam int            PW   = (FCOUNT > 2) ? $clog2(FCOUNT) : 1;
    localparam logic [PW-1:0] PMAX = PW'(FCOUNT - 1);

    logic [PW-1:0] pre;
    logic          tick;
    logic          tick_up;
    logic          tick_dn;
    logic          edit_ok;
    logic [3:0]    e_inc;
    logic [3:0]    e_dec;
    logic          msec_co, sec_co, min_co, hour_co;
    logic          msec_bo, sec_bo, min_bo, hour_bo;
    logic          at_one;

    // Prescaler: free-runs 0..FCOUNT-1 while run is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pre <= '0;
        else if (clr)
            pre <= '0;
        else if (run)
            pre <= (pre == PMAX) ? '0 : pre + 1'b1;
    end

    assign tick    = run & ~clr & (pre == PMAX);
    assign tick_up = tick & ~dir;
    // Down-count holds at zero rather than wrapping to 23:59:59.99.
    assign tick_dn = tick & dir & ~zero;

    assign edit_ok = (inc ^ dec) & ~clr;

    always_comb begin
        e_inc = '0;
        e_dec = '0;
        e_inc[sel] = edit_ok & inc;
        e_dec[sel] = edit_ok & dec;
    end

    watch_field #(.MOD(MSEC_MOD), .W(MSEC_W), .RST_VAL('0)) u_msec (
        .clk(clk), .rst(rst), .clr(clr),
        .ci(tick_up), .bi(tick_dn),
        .edit_inc(e_inc[SEL_MSEC]), .edit_dec(e_dec[SEL_MSEC]),
        .val(msec), .co(msec_co), .bo(msec_bo)
    );

    watch_field #(.MOD(SEC_MOD), .W(SEC_W), .RST_VAL('0)) u_sec (
        .clk(clk), .rst(rst), .clr(clr),
        .ci(msec_co), .bi(msec_bo),
        .edit_inc(e_inc[SEL_SEC]), .edit_dec(e_dec[SEL_SEC]),
        .val(sec), .co(sec_co), .bo(sec_bo)
    );

    watch_field #(.MOD(MIN_MOD), .W(MIN_W), .RST_VAL('0)) u_min (
        .clk(clk), .rst(rst), .clr(clr),
        .ci(sec_co), .bi(sec_bo),
        .edit_inc(e_inc[SEL_MIN]), .edit_dec(e_dec[SEL_MIN]),
        .val(min), .co(min_co), .bo(min_bo)
    );

    watch_field #(.MOD(HOUR_MOD), .W(HOUR_W), .RST_VAL(HOUR_W'(RST_HOUR))) u_hour (
        .clk(clk), .rst(rst), .clr(clr),
        .ci(min_co), .bi(min_bo),
        .edit_inc(e_inc[SEL_HOUR]), .edit_dec(e_dec[SEL_HOUR]),
        .val(hour), .co(hour_co), .bo(hour_bo)
    );

    assign zero = (msec == '0) && (sec == '0) && (min == '0) && (hour == '0);

    // 00:00:00.01: the only state from which a down-tick lands on zero.
    assign at_one = (msec == MSEC_W'(1)) && (sec == '0) && (min == '0) && (hour == '0);

    // Any edit either overrides msec or sets a higher field non-zero,
    // so an edit in the same cycle never yields an expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            expired  <= 1'b0;
            day_tick <= 1'b0;
        end else begin
            expired  <= tick_dn & ~edit_ok & at_one;
            day_tick <= hour_co;
        end
    end

    // Borrow out of the hour stage cannot occur: zero blocks tick_dn.
    logic unused;
    assign unused = hour_bo;

endmodule

// File: tb/tb_watch_timer_dp.sv
module tb_watch_timer_dp;

    logic       clk = 0;
    logic       rst, run, dir, clr, inc, dec;
    logic [1:0] sel;
    logic [6:0] msec;
    logic [5:0] sec, min;
    logic [4:0] hour;
    logic       zero, expired, day_tick;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    watch_timer_dp #(.FCOUNT(4), .RST_HOUR(12)) dut (
        .clk(clk), .rst(rst), .run(run), .dir(dir), .clr(clr),
        .sel(sel), .inc(inc), .dec(dec),
        .msec(msec), .sec(sec), .min(min), .hour(hour),
        .zero(zero), .expired(expired), .day_tick(day_tick)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic edit(input logic [1:0] s, input logic i, input logic d);
        sel = s; inc = i; dec = d;
        cyc(1);
        inc = 0; dec = 0;
    endtask

    task automatic do_clr();
        clr = 1;
        cyc(1);
        clr = 0;
    endtask

    task automatic test_reset();
        cyc(2);
        vec++;
        if ({hour, min, sec, msec} !== {5'd12, 6'd0, 6'd0, 7'd0}) begin
            errs++; $display("FAIL reset_time got %h exp %h", {hour, min, sec, msec}, {5'd12, 6'd0, 6'd0, 7'd0});
        end
        vec++;
        if ({zero, expired, day_tick} !== 3'b000) begin
            errs++; $display("FAIL reset_flags got %b exp 000", {zero, expired, day_tick});
        end
    endtask

    task automatic test_first_tick();
        rst = 0;
        cyc(1);
        run = 1;
        cyc(3);
        vec++;
        if (msec !== 7'd0) begin
            errs++; $display("FAIL first_tick_early msec got %0d exp 0", msec);
        end
        cyc(1);
        vec++;
        if ({hour, msec, day_tick} !== {5'd12, 7'd1, 1'b0}) begin
            errs++; $display("FAIL first_tick hour/msec/day got %0d/%0d/%0d exp 12/1/0", hour, msec, day_tick);
        end
        run = 0;
    endtask

    task automatic test_day_wrap();
        do_clr();
        edit(2'd0, 0, 1);
        edit(2'd1, 0, 1);
        edit(2'd2, 0, 1);
        edit(2'd3, 0, 1);
        vec++;
        if ({hour, min, sec, msec} !== {5'd23, 6'd59, 6'd59, 7'd99}) begin
            errs++; $display("FAIL load_2359 got %0d:%0d:%0d.%0d exp 23:59:59.99", hour, min, sec, msec);
        end
        run = 1;
        cyc(3);
        vec++;
        if ({msec, day_tick} !== {7'd99, 1'b0}) begin
            errs++; $display("FAIL pre_wrap msec/day got %0d/%0d exp 99/0", msec, day_tick);
        end
        cyc(1);
        run = 0;
        vec++;
        if ({hour, min, sec, msec, day_tick} !== {5'd0, 6'd0, 6'd0, 7'd0, 1'b1}) begin
            errs++; $display("FAIL day_wrap got %0d:%0d:%0d.%0d day=%0d exp 0:0:0.0 day=1", hour, min, sec, msec, day_tick);
        end
        cyc(1);
        vec++;
        if (day_tick !== 1'b0) begin
            errs++; $display("FAIL day_tick_width got %0d exp 0", day_tick);
        end
    endtask

    task automatic test_edit_wrap();
        edit(2'd1, 0, 1);
        vec++;
        if (sec !== 6'd59) begin
            errs++; $display("FAIL sec_dec_wrap got %0d exp 59", sec);
        end
        edit(2'd1, 1, 0);
        vec++;
        if ({min, sec} !== {6'd0, 6'd0}) begin
            errs++; $display("FAIL sec_inc_wrap min/sec got %0d/%0d exp 0/0", min, sec);
        end
        edit(2'd0, 0, 1);
        edit(2'd0, 1, 0);
        vec++;
        if ({sec, msec} !== {6'd0, 7'd0}) begin
            errs++; $display("FAIL msec_edit_wrap sec/msec got %0d/%0d exp 0/0", sec, msec);
        end
        edit(2'd3, 0, 1);
        vec++;
        if (hour !== 5'd23) begin
            errs++; $display("FAIL hour_dec_wrap got %0d exp 23", hour);
        end
        edit(2'd3, 1, 0);
        vec++;
        if (hour !== 5'd0) begin
            errs++; $display("FAIL hour_inc_wrap got %0d exp 0", hour);
        end
    endtask

    task automatic test_inc_dec_both();
        edit(2'd2, 1, 1);
        vec++;
        if (min !== 6'd0) begin
            errs++; $display("FAIL both_edit0 min got %0d exp 0", min);
        end
        edit(2'd2, 1, 0);
        edit(2'd2, 1, 1);
        vec++;
        if (min !== 6'd1) begin
            errs++; $display("FAIL both_edit1 min got %0d exp 1", min);
        end
    endtask

    task automatic test_carry();
        do_clr();
        edit(2'd0, 0, 1);
        edit(2'd1, 0, 1);
        run = 1;
        cyc(4);
        run = 0;
        vec++;
        if ({hour, min, sec, msec} !== {5'd0, 6'd1, 6'd0, 7'd0}) begin
            errs++; $display("FAIL carry_chain got %0d:%0d:%0d.%0d exp 0:1:0.0", hour, min, sec, msec);
        end
    endtask

    task automatic test_edit_tick_collision();
        do_clr();
        edit(2'd0, 0, 1);
        run = 1; sel = 2'd1;
        cyc(3);
        inc = 1;
        cyc(1);
        inc = 0; run = 0;
        vec++;
        if ({min, sec, msec} !== {6'd0, 6'd1, 7'd0}) begin
            errs++; $display("FAIL edit_tick min/sec/msec got %0d/%0d/%0d exp 0/1/0", min, sec, msec);
        end
    endtask

    task automatic test_countdown();
        int np = 0;
        do_clr();
        edit(2'd1, 1, 0);
        dir = 1; run = 1;
        cyc(4);
        vec++;
        if ({hour, min, sec, msec, expired} !== {5'd0, 6'd0, 6'd0, 7'd99, 1'b0}) begin
            errs++; $display("FAIL down_first got %0d:%0d:%0d.%0d exp=%0d exp 0:0:0.99 exp=0", hour, min, sec, msec, expired);
        end
        for (int i = 0; i < 396; i++) begin
            cyc(1);
            if (expired) np++;
        end
        vec++;
        if ({zero, expired, msec} !== {1'b1, 1'b1, 7'd0}) begin
            errs++; $display("FAIL down_zero zero/expired/msec got %0d/%0d/%0d exp 1/1/0", zero, expired, msec);
        end
        for (int i = 0; i < 32; i++) begin
            cyc(1);
            if (expired) np++;
        end
        vec++;
        if (np !== 1) begin
            errs++; $display("FAIL expired_count got %0d exp 1", np);
        end
        vec++;
        if ({hour, min, sec, msec, zero} !== {5'd0, 6'd0, 6'd0, 7'd0, 1'b1}) begin
            errs++; $display("FAIL down_hold got %0d:%0d:%0d.%0d zero=%0d exp 0:0:0.0 zero=1", hour, min, sec, msec, zero);
        end
        run = 0; dir = 0;
    endtask

    task automatic test_async_reset();
        edit(2'd2, 1, 0);
        run = 1;
        cyc(6);
        #2 rst = 1;
        #1;
        vec++;
        if ({hour, min, sec, msec} !== {5'd12, 6'd0, 6'd0, 7'd0}) begin
            errs++; $display("FAIL async_rst got %0d:%0d:%0d.%0d exp 12:0:0.0", hour, min, sec, msec);
        end
        @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_clr();
        cyc(7);
        vec++;
        if (msec !== 7'd1) begin
            errs++; $display("FAIL pre_clr msec got %0d exp 1", msec);
        end
        clr = 1;
        cyc(1);
        clr = 0;
        vec++;
        if ({hour, min, sec, msec, expired, day_tick} !== {5'd0, 6'd0, 6'd0, 7'd0, 1'b0, 1'b0}) begin
            errs++; $display("FAIL clr got %0d:%0d:%0d.%0d exp 0:0:0.0", hour, min, sec, msec);
        end
        cyc(3);
        vec++;
        if (msec !== 7'd0) begin
            errs++; $display("FAIL clr_pre_reset msec got %0d exp 0", msec);
        end
        cyc(1);
        vec++;
        if (msec !== 7'd1) begin
            errs++; $display("FAIL clr_next_tick msec got %0d exp 1", msec);
        end
        run = 0;
    endtask

    initial begin
        rst = 1; run = 0; dir = 0; clr = 0; inc = 0; dec = 0; sel = 2'd0;
        test_reset();
        test_first_tick();
        test_day_wrap();
        test_edit_wrap();
        test_inc_dec_both();
        test_carry();
        test_edit_tick_collision();
        test_countdown();
        test_async_reset();
        test_clr();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
